// File: rtl/sc_reglanebank_pkg.sv
// Shared widths, direction codes and rotate helpers for the lane bank.
// Rotate helpers work on a wide word and mask to the lane width in use.
package sc_reglanebank_pkg;

  localparam int DEF_LANE_WIDTH   = 8;
  localparam int DEF_LANE_COUNT   = 4;
  localparam int DEF_PERIOD_WIDTH = 8;
  localparam int LANE_SEL_WIDTH   = $clog2(DEF_LANE_COUNT);

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int ROT_MAX_WIDTH = 64;
  typedef logic [ROT_MAX_WIDTH-1:0] rot_word_t;

  function automatic rot_word_t rot_mask(input int w);
    return {ROT_MAX_WIDTH{1'b1}} >> (ROT_MAX_WIDTH - w);
  endfunction

  // MSB wraps into bit 0
  function automatic rot_word_t rot_left(
    input rot_word_t r,
    input int        w
  );
    return ((r << 1) | (r >> (w - 1))) & rot_mask(w);
  endfunction

  // bit 0 wraps into the MSB
  function automatic rot_word_t rot_right(
    input rot_word_t r,
    input int        w
  );
    return ((r >> 1) | (r << (w - 1))) & rot_mask(w);
  endfunction

endpackage

// File: rtl/sc_reglanebank_tick.sv
// Per-lane prescaler: counts enabled cycles and flags a tick when the
// count reaches period-1; a lowered period wraps on the next cycle.
module sc_lane_tick
  import sc_reglanebank_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    restart_i,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    tick_o
);

  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic [PERIOD_WIDTH-1:0] cnt_d;
  logic                    active;

  assign active = enable_i && (period_i != '0);
  assign tick_o = active &&
    (cnt_q >= period_i - PERIOD_WIDTH'(1));

  // next count: clear/restart win, zero period parks at 0
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (!active || tick_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PERIOD_WIDTH'(1);
      end
    end
  end

  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_reglanebank.sv
// Multi-lane auto-rotating row bank for the obstacle field.
// Optional column probe enabled with SC_REGLANEBANK_PROBE_EN.
module sc_reglanebank
  import sc_reglanebank_pkg::*;
#(
  parameter int LANE_WIDTH   = DEF_LANE_WIDTH,
  parameter int LANE_COUNT   = DEF_LANE_COUNT,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter logic [LANE_WIDTH-1:0] DATA_FIXED_INITLANE = '0,
  localparam int SEL_W =
    (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1,
  localparam int COL_W =
    (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1
) (
  input  logic                  SC_RegLANEBANK_CLOCK_50,
  input  logic                  SC_RegLANEBANK_RESET_InHigh,
  input  logic                  SC_RegLANEBANK_clear_InLow,
  input  logic                  SC_RegLANEBANK_load_InLow,
  input  logic [SEL_W-1:0]      SC_RegLANEBANK_loadSel_In,
  input  logic [LANE_WIDTH-1:0] SC_RegLANEBANK_data_InBUS,
  input  logic                  SC_RegLANEBANK_enable_In,
  input  logic [LANE_COUNT-1:0] SC_RegLANEBANK_dir_InBUS,
  input  logic [LANE_COUNT*PERIOD_WIDTH-1:0]
                                SC_RegLANEBANK_period_InBUS,
  output logic [LANE_COUNT*LANE_WIDTH-1:0]
                                SC_RegLANEBANK_data_OutBUS,
  output logic [LANE_COUNT-1:0] SC_RegLANEBANK_step_OutBUS
`ifdef SC_REGLANEBANK_PROBE_EN
  ,
  input  logic [COL_W-1:0]      SC_RegLANEBANK_probeCol_In,
  output logic [LANE_COUNT-1:0] SC_RegLANEBANK_probe_OutBUS
`endif
);

  logic                  clk;
  logic                  rst;
  logic                  clear;
  logic [LANE_WIDTH-1:0] row_q [LANE_COUNT];
  logic [LANE_WIDTH-1:0] row_d [LANE_COUNT];
  logic [LANE_COUNT-1:0] step_q;
  logic [LANE_COUNT-1:0] step_d;
  logic [LANE_COUNT-1:0] tick;
  logic [LANE_COUNT-1:0] load_hit;

  assign clk   = SC_RegLANEBANK_CLOCK_50;
  assign rst   = SC_RegLANEBANK_RESET_InHigh;
  assign clear = ~SC_RegLANEBANK_clear_InLow;

  // one-hot load decode; out-of-range selects hit nothing
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      load_hit[i] = ~SC_RegLANEBANK_load_InLow &&
        (int'(SC_RegLANEBANK_loadSel_In) == i);
    end
  end

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    sc_lane_tick #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_tick (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (clear),
      .restart_i(load_hit[g]),
      .enable_i (SC_RegLANEBANK_enable_In),
      .period_i (SC_RegLANEBANK_period_InBUS[
                   g*PERIOD_WIDTH +: PERIOD_WIDTH]),
      .tick_o   (tick[g])
    );

    assign SC_RegLANEBANK_data_OutBUS[
      g*LANE_WIDTH +: LANE_WIDTH] = row_q[g];
  end

  // per-lane priority: clear > load > rotate > hold
  always_comb begin
    step_d = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      row_d[i] = row_q[i];
      if (clear) begin
        row_d[i] = DATA_FIXED_INITLANE;
      end else if (load_hit[i]) begin
        row_d[i] = SC_RegLANEBANK_data_InBUS;
      end else if (tick[i]) begin
        step_d[i] = 1'b1;
        unique case (SC_RegLANEBANK_dir_InBUS[i])
          DIR_LEFT:  row_d[i] = LANE_WIDTH'(rot_left(
                       rot_word_t'(row_q[i]), LANE_WIDTH));
          DIR_RIGHT: row_d[i] = LANE_WIDTH'(rot_right(
                       rot_word_t'(row_q[i]), LANE_WIDTH));
        endcase
      end
    end
  end

  // row and step registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANE_COUNT; i++) begin
        row_q[i] <= '0;
      end
      step_q <= '0;
    end else begin
      for (int i = 0; i < LANE_COUNT; i++) begin
        row_q[i] <= row_d[i];
      end
      step_q <= step_d;
    end
  end

  assign SC_RegLANEBANK_step_OutBUS = step_q;

`ifdef SC_REGLANEBANK_PROBE_EN
  // column probe for collision checks
  always_comb begin
    SC_RegLANEBANK_probe_OutBUS = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      if (int'(SC_RegLANEBANK_probeCol_In) < LANE_WIDTH) begin
        SC_RegLANEBANK_probe_OutBUS[i] =
          row_q[i][SC_RegLANEBANK_probeCol_In];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sc_reglanebank.sv
// Directed bench for sc_reglanebank with immediate assertions.
module tb_sc_reglanebank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_n = 1'b1;
  logic        ld_n = 1'b1;
  logic [1:0]  sel = '0;
  logic [7:0]  din = '0;
  logic        en = 1'b0;
  logic [3:0]  dir = '0;
  logic [31:0] per = '0;
  wire  [31:0] dout;
  wire  [3:0]  stp;
`ifdef SC_REGLANEBANK_PROBE_EN
  logic [2:0]  pcol = '0;
  wire  [3:0]  probe;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_d [9];
  logic [3:0]  exp_s [9];

  always #5 clk = ~clk;

  sc_reglanebank dut (
    .SC_RegLANEBANK_CLOCK_50    (clk),
    .SC_RegLANEBANK_RESET_InHigh(rst),
    .SC_RegLANEBANK_clear_InLow (clr_n),
    .SC_RegLANEBANK_load_InLow  (ld_n),
    .SC_RegLANEBANK_loadSel_In  (sel),
    .SC_RegLANEBANK_data_InBUS  (din),
    .SC_RegLANEBANK_enable_In   (en),
    .SC_RegLANEBANK_dir_InBUS   (dir),
    .SC_RegLANEBANK_period_InBUS(per),
    .SC_RegLANEBANK_data_OutBUS (dout),
    .SC_RegLANEBANK_step_OutBUS (stp)
`ifdef SC_REGLANEBANK_PROBE_EN
    ,
    .SC_RegLANEBANK_probeCol_In (pcol),
    .SC_RegLANEBANK_probe_OutBUS(probe)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_d = '{32'h00A54001, 32'h00A52001, 32'h00A51002,
              32'h00A50802, 32'h00A50402, 32'h00A50204,
              32'h00A50104, 32'h00A58004, 32'h00A54008};
    exp_s = '{4'b0010, 4'b0010, 4'b0011,
              4'b0010, 4'b0010, 4'b0011,
              4'b0010, 4'b0010, 4'b0011};

    #2 rst = 1'b1;
    #1;
    chk("reset_data", dout, 32'h0);
    chk("reset_step", {28'h0, stp}, 32'h0);
    #9 rst = 1'b0;

    per = {8'd0, 8'd0, 8'd1, 8'd3};
    dir = 4'b0001;
    ld_n = 1'b0; sel = 2'd0; din = 8'h01;
    cyc();
    sel = 2'd1; din = 8'h80;
    cyc();
    sel = 2'd2; din = 8'hA5;
    cyc();
    ld_n = 1'b1;
    chk("loaded_rows", dout, 32'h00A58001);
    chk("loaded_step", {28'h0, stp}, 32'h0);
    en = 1'b1;

    for (int k = 0; k < 9; k++) begin
      cyc();
      chk($sformatf("run_data_%0d", k + 1), dout, exp_d[k]);
      chk($sformatf("run_step_%0d", k + 1),
          {28'h0, stp}, {28'h0, exp_s[k]});
    end

    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("p0_row2_%0d", k), {24'h0, dout[23:16]},
          32'hA5);
      chk($sformatf("p0_step2_%0d", k), {31'h0, stp[2]}, 32'h0);
    end
    per[23:16] = 8'd2;
    cyc();
    chk("p2_row2_a", {24'h0, dout[23:16]}, 32'hA5);
    chk("p2_step2_a", {31'h0, stp[2]}, 32'h0);
    cyc();
    chk("p2_row2_b", {24'h0, dout[23:16]}, 32'hD2);
    chk("p2_step2_b", {31'h0, stp[2]}, 32'h1);

    dir[3] = 1'b1;
    per[31:24] = 8'd10;
    ld_n = 1'b0; sel = 2'd3; din = 8'h81;
    cyc();
    ld_n = 1'b1;
    chk("l3_load", {24'h0, dout[31:24]}, 32'h81);
    repeat (3) cyc();
    cyc();
    chk("l3_cnt4_row", {24'h0, dout[31:24]}, 32'h81);
    chk("l3_cnt4_step", {31'h0, stp[3]}, 32'h0);
    per[31:24] = 8'd3;
    cyc();
    chk("l3_shrink_row", {24'h0, dout[31:24]}, 32'h03);
    chk("l3_shrink_step", {31'h0, stp[3]}, 32'h1);

    per[31:24] = 8'd4;
    cyc();
    cyc();
    ld_n = 1'b0; sel = 2'd3; din = 8'h10;
    cyc();
    ld_n = 1'b1;
    chk("mid_load_row", {24'h0, dout[31:24]}, 32'h10);
    chk("mid_load_step", {31'h0, stp[3]}, 32'h0);
    repeat (2) cyc();
    cyc();
    chk("mid_hold_row", {24'h0, dout[31:24]}, 32'h10);
    chk("mid_hold_step", {31'h0, stp[3]}, 32'h0);
    cyc();
    chk("mid_rot_row", {24'h0, dout[31:24]}, 32'h20);
    chk("mid_rot_step", {31'h0, stp[3]}, 32'h1);

    clr_n = 1'b0;
    ld_n = 1'b0; sel = 2'd1; din = 8'hFF;
    cyc();
    clr_n = 1'b1;
    ld_n = 1'b1;
    chk("clr_ld_data", dout, 32'h0);
    chk("clr_ld_step", {28'h0, stp}, 32'h0);

    ld_n = 1'b0; sel = 2'd0; din = 8'h0F;
    cyc();
    ld_n = 1'b1;
    chk("pre_rst_data", dout, 32'h0000000F);
    chk("pre_rst_step", {28'h0, stp}, 32'h2);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_data", dout, 32'h0);
    chk("async_rst_step", {28'h0, stp}, 32'h0);
    #1 rst = 1'b0;
    cyc();
    chk("post_rst_step1", {28'h0, stp}, 32'h2);
    cyc();
    chk("post_rst_step2", {28'h0, stp}, 32'h6);
    cyc();
    chk("post_rst_step3", {28'h0, stp}, 32'h3);
    cyc();
    chk("post_rst_step4", {28'h0, stp}, 32'hE);
    chk("post_rst_data", dout, 32'h0);

`ifdef SC_REGLANEBANK_PROBE_EN
    en = 1'b0;
    ld_n = 1'b0; sel = 2'd0; din = 8'h01;
    cyc();
    sel = 2'd1; din = 8'h80;
    cyc();
    sel = 2'd2; din = 8'h00;
    cyc();
    sel = 2'd3; din = 8'hFF;
    cyc();
    ld_n = 1'b1;
    pcol = 3'd0;
    #1;
    chk("probe_col0", {28'h0, probe}, 32'h9);
    pcol = 3'd7;
    #1;
    chk("probe_col7", {28'h0, probe}, 32'hA);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_reglanebank.md
Name: sc_reglanebank

Overview:
- Parametrised multi-lane successor to the single point-type register, used for the Frogger obstacle field.
- Holds LANE_COUNT independent rows of LANE_WIDTH bits each.
- Each lane auto-rotates left or right at its own programmable speed, using an internal prescaler counter per lane.
- Sits between the game FSM (load/clear/speed control) and the display/collision logic (reads the rows).

Parameters:
- LANE_WIDTH, 8, bits per lane row.
- LANE_COUNT, 4, number of lanes.
- PERIOD_WIDTH, 8, width of each lane's period field and counter.
- DATA_FIXED_INITLANE, 8'b00000000, value every lane takes on synchronous clear.

Ports:
- SC_RegLANEBANK_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- SC_RegLANEBANK_RESET_InHigh  in  1  reset; asynchronous, active-high.
- SC_RegLANEBANK_clear_InLow  in  1  synchronous clear of all lanes and counters.
- SC_RegLANEBANK_load_InLow  in  1  load the selected lane.
- SC_RegLANEBANK_loadSel_In  in  $clog2(LANE_COUNT)  lane index for load.
- SC_RegLANEBANK_data_InBUS  in  LANE_WIDTH  load data.
- SC_RegLANEBANK_enable_In  in  1  global run; 0 freezes all counters and rows.
- SC_RegLANEBANK_dir_InBUS  in  LANE_COUNT  per-lane direction: 1 = rotate left, 0 = rotate right.
- SC_RegLANEBANK_period_InBUS  in  LANE_COUNT*PERIOD_WIDTH  per-lane period in cycles; lane i occupies slice [i*PERIOD_WIDTH +: PERIOD_WIDTH]; 0 = lane frozen.
- SC_RegLANEBANK_data_OutBUS  out  LANE_COUNT*LANE_WIDTH  registered rows; lane i occupies slice [i*LANE_WIDTH +: LANE_WIDTH].
- SC_RegLANEBANK_step_OutBUS  out  LANE_COUNT  registered one-cycle pulse, high in the same cycle the rotated row first appears on the output.

Behaviour:
- Reset (async, high): all rows = 0 (not DATA_FIXED_INITLANE), all counters = 0, step = 0. Takes effect immediately, including mid-count.
- Per-lane priority each cycle: clear > load (lane == loadSel) > rotate-tick > hold.
- Clear (low): every row = DATA_FIXED_INITLANE, every counter = 0, step = 0.
- Load (low, loadSel < LANE_COUNT): that row = data_InBUS, its counter = 0, its step = 0. Other lanes continue normally in the same cycle. loadSel >= LANE_COUNT: load ignored.
- Tick: when enable = 1 and period != 0, counter increments each cycle. When counter >= period-1: counter = 0, row rotates, step = 1 next cycle.
  - ">=" makes a period reduced below the current count wrap on the next cycle; the counter never runs to its maximum.
- Rotate left: {R[W-2:0], R[W-1]}. Rotate right: {R[0], R[W-1:1]}.
- Direction is sampled on the tick cycle; changing it between ticks has no other effect.
- enable = 0: counters and rows hold, step = 0. Load and clear still act.
- period = 1: lane rotates every cycle; step stays high continuously.
- period = 0: counter held at 0, no rotation, step = 0.
- Latency: load/clear visible on data_OutBUS one cycle after the sampling edge.

Optional Feature:
- Macro: SC_REGLANEBANK_PROBE_EN.
- Defined: adds input SC_RegLANEBANK_probeCol_In ($clog2(LANE_WIDTH)) and output SC_RegLANEBANK_probe_OutBUS (LANE_COUNT).
  - Output bit i = row i bit [probeCol], combinational from the registers; used for frog collision detection.
  - probeCol >= LANE_WIDTH gives 0.
- Undefined: both ports absent; no probe logic.

Decomposition:
- Package sc_reglanebank_pkg: localparams for default widths, LANE_SEL_WIDTH, DIR_LEFT = 1'b1, DIR_RIGHT = 1'b0, and rotate-left/right functions.
- Sub-module sc_lane_tick: per-lane prescaler. Inputs: clock, reset, clear, restart, enable, period. Output: tick. Instantiated LANE_COUNT times by generate.
- Row registers and priority mux stay in the top.

Test Plan:
- Reset, then load lane0 = 8'b00000001, period0 = 3, dir0 = 1, enable = 1 -> row0 = 00000010 after 3 cycles, 00000100 after 6; step[0] high exactly in those cycles.
- Lane1 = 8'b10000000, period1 = 1, dir1 = 0 -> 01000000, 00100000, ... each cycle, wrapping to 10000000 after 8; step[1] stays high.
- period2 = 0 with enable = 1 -> row2 and step[2] unchanged for 20 cycles. Set period2 = 2 -> first rotation 2 cycles later.
- Count lane0 to 4 with period = 10, then set period = 3 -> wrap and rotate on the next cycle.
- Load lane0 mid-count (cnt = 2, period = 4) -> row = new data, next rotation 4 cycles later. Same cycle: clear + load -> all lanes = DATA_FIXED_INITLANE.
- Assert reset asynchronously mid-cycle while running -> outputs 0 immediately, before the next edge. Release -> counters restart from 0.
- With PROBE_EN: rows {0x01, 0x80, 0x00, 0xFF}, probeCol = 0 -> probe_OutBUS = 4'b1001.
